mmm_r2mm_sched: RTL and testbench

MMM_R2MM_SCHED -- requirements
Module: mmm_r2mm_sched

---
 rtl/mmm_pkg.sv | 14 +
 rtl/mmm_r2mm_sched_rr_arb2.sv | 24 ++
 rtl/mmm_r2mm_sched.sv | 118 +++++++++++
 tb/tb_mmm_r2mm_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_pkg.sv
// Shared definitions for the Montgomery-multiply request scheduler.
package mmm_pkg;

    localparam int MMM_K   = 4096;
    localparam int MMM_TMO = 3 * MMM_K;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/mmm_r2mm_sched_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, grant the requester not served last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       acc,
    output logic [1:0] gnt
);

    logic last;

    // One-hot grant; a lone requester always wins, a tie goes to the other side of 'last'.
    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
    end

    // Remember who was served; reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      last <= 1'b1;
        else if (acc) last <= gnt[1];
    end

endmodule

// File: rtl/mmm_r2mm_sched.sv
// Shares one Montgomery core between two requesters with a response timeout.
module mmm_r2mm_sched
    import mmm_pkg::*;
#(
    parameter int K   = MMM_K,
    parameter int TMO = 3 * K
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [K-1:0]   x0,
    input  logic [K-1:0]   y0,
    input  logic [K-1:0]   m0,
    input  logic [K-1:0]   x1,
    input  logic [K-1:0]   y1,
    input  logic [K-1:0]   m1,
    output logic [1:0]     rsp_valid,
    output logic           rsp_err,
    output logic [K-1:0]   rsp_res,
    output logic [K-1:0]   core_x,
    output logic [K-1:0]   core_y,
    output logic [K-1:0]   core_m,
    output logic           core_req,
    input  logic [K-1:0]   core_res,
    input  logic           core_val,
    output logic           busy
);

    localparam int CW = $clog2(TMO + 1);

    state_t          state, state_d;
    logic [1:0]      gnt;
    logic            acc, done_ok, done_to, owner;
    logic [CW-1:0]   cnt;

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req_valid),
        .acc (acc),
        .gnt (gnt)
    );

    // Ready is the only combinational output: the grant, offered only while idle.
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && !rst) req_ready = gnt;
    end

    assign acc = |(req_valid & req_ready);

    // Next state; core_val only matters in WAIT and beats a coincident timeout.
    always_comb begin
        state_d = state;
        done_ok = 1'b0;
        done_to = 1'b0;
        case (state)
            IDLE:  if (acc) state_d = ISSUE;
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (core_val) begin
                    done_ok = 1'b1;
                    state_d = RESP;
                end else if (cnt == CW'(TMO - 1)) begin
                    done_to = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Registered datapath: operand latch, start pulse, timeout counter, response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= 1'b0;
            core_x    <= '0;
            core_y    <= '0;
            core_m    <= '0;
            core_req  <= 1'b0;
            cnt       <= '0;
            rsp_valid <= 2'b00;
            rsp_err   <= 1'b0;
            rsp_res   <= '0;
            busy      <= 1'b0;
        end else begin
            core_req  <= acc;
            rsp_valid <= 2'b00;
            busy      <= (state_d != IDLE);
            if (acc) begin
                owner  <= req_ready[1];
                core_x <= req_ready[1] ? x1 : x0;
                core_y <= req_ready[1] ? y1 : y0;
                core_m <= req_ready[1] ? m1 : m0;
            end
            if (state == ISSUE)     cnt <= '0;
            else if (state == WAIT) cnt <= cnt + CW'(1);
            if (done_ok) begin
                rsp_res   <= core_res;
                rsp_err   <= 1'b0;
                rsp_valid <= {owner, ~owner};
            end else if (done_to) begin
                rsp_res   <= '0;
                rsp_err   <= 1'b1;
                rsp_valid <= {owner, ~owner};
            end
        end
    end

endmodule

// File: tb/tb_mmm_r2mm_sched.sv
// Randomized + directed bench for mmm_r2mm_sched against a transaction-level model.
module tb_mmm_r2mm_sched;

    localparam int K   = 16;
    localparam int TMO = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid, req_ready, rsp_valid;
    logic [K-1:0]  x0, y0, m0, x1, y1, m1;
    logic          rsp_err, core_req, core_val, busy;
    logic [K-1:0]  rsp_res, core_x, core_y, core_m, core_res;

    mmm_r2mm_sched #(.K(K), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .x0(x0), .y0(y0), .m0(m0), .x1(x1), .y1(y1), .m1(m1),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_res(rsp_res),
        .core_x(core_x), .core_y(core_y), .core_m(core_m), .core_req(core_req),
        .core_res(core_res), .core_val(core_val), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- behavioural core ----------------
    int core_dly  = 20;   // 0 = never answers
    int stray_cyc = -1;
    int unsigned cx = 0, cy = 0, cm = 1;
    int tgt = -1;

    initial begin
        core_val = 1'b0;
        core_res = '0;
        forever begin
            @(posedge clk);
            #1;
            if (core_req) begin
                cx  = int'(core_x);
                cy  = int'(core_y);
                cm  = (core_m == 0) ? 1 : int'(core_m);
                tgt = (core_dly == 0) ? -1 : cyc + core_dly;
            end
            if (cyc == tgt || cyc == stray_cyc) begin
                core_val = 1'b1;
                core_res = K'((cx * cy) % cm);
                if (cyc == tgt) tgt = -1;
            end else begin
                core_val = 1'b0;
            end
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct { logic [1:0] v; int c; logic [K-1:0] res; logic err; } rsp_t;
    rsp_t rsp_q[$];
    int   acc_g[$];
    int   acc_c[$];
    logic [1:0] last_acc = 2'b00;

    int          m_acc = -100, m_rsp = -100;
    logic        m_last = 1'b1, m_own = 1'b0, m_err = 1'b0;
    logic [K-1:0] m_x, m_y, m_m, m_res;

    function automatic logic [1:0] rr_pick(input logic [1:0] r, input logic last);
        if (r == 2'b11) return last ? 2'b01 : 2'b10;
        return r;
    endfunction

    always @(negedge clk) begin
        logic       idle;
        logic [1:0] exp_rdy;
        int unsigned a, b, mm;
        if (rst) begin
            m_acc  = -100;
            m_rsp  = -100;
            m_last = 1'b1;
            last_acc = 2'b00;
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_core_req", 32'(core_req), 32'd0);
        end else begin
            idle    = (cyc > m_rsp);
            exp_rdy = idle ? rr_pick(req_valid, m_last) : 2'b00;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(!idle));
            chk("core_req", 32'(core_req), 32'(cyc == m_acc + 1));
            if (cyc > m_acc && cyc < m_rsp) begin
                chk("core_x", 32'(core_x), 32'(m_x));
                chk("core_y", 32'(core_y), 32'(m_y));
                chk("core_m", 32'(core_m), 32'(m_m));
            end
            chk("rsp_valid", 32'(rsp_valid), (cyc == m_rsp) ? (m_own ? 32'd2 : 32'd1) : 32'd0);
            if (cyc == m_rsp) begin
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
                chk("rsp_res", 32'(rsp_res), 32'(m_res));
            end
            if (rsp_valid != 2'b00) rsp_q.push_back('{rsp_valid, cyc, rsp_res, rsp_err});
            last_acc = req_valid & req_ready;
            if (last_acc != 2'b00) begin
                acc_g.push_back(int'(last_acc[1]));
                acc_c.push_back(cyc);
            end
            if (exp_rdy != 2'b00) begin
                m_own  = exp_rdy[1];
                m_last = exp_rdy[1];
                m_x    = m_own ? x1 : x0;
                m_y    = m_own ? y1 : y0;
                m_m    = m_own ? m1 : m0;
                m_acc  = cyc;
                if (core_dly >= 1 && core_dly <= TMO) begin
                    a = int'(m_x); b = int'(m_y); mm = int'(m_m);
                    m_res = K'((a * b) % mm);
                    m_err = 1'b0;
                    m_rsp = cyc + 2 + core_dly;
                end else begin
                    m_res = '0;
                    m_err = 1'b1;
                    m_rsp = cyc + 2 + TMO;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~last_acc;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while ((req_valid != 2'b00 || busy) && n < maxc) begin
            step();
            n++;
        end
        if (n >= maxc) chk("idle_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        req_valid = 2'b00;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic clr_logs();
        rsp_q.delete();
        acc_g.delete();
        acc_c.delete();
    endtask

    task automatic rnd_ops();
        x0 = K'($urandom); y0 = K'($urandom); m0 = K'($urandom_range(1, 65535));
        x1 = K'($urandom); y1 = K'($urandom); m1 = K'($urandom_range(1, 65535));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        {x0, y0, m0, x1, y1, m1} = '0;
        do_reset(3);
        chk("rst_rsp_res", 32'(rsp_res), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_core_x", 32'(core_x), 32'd0);

        // single request, fixed latency
        clr_logs();
        core_dly = 20;
        x0 = 16'd3; y0 = 16'd5; m0 = 16'd7;
        req_valid = 2'b01;
        wait_idle(100);
        chk("single_cnt", 32'(rsp_q.size()), 32'd1);
        if (rsp_q.size() == 1 && acc_c.size() == 1) begin
            chk("single_v", 32'(rsp_q[0].v), 32'd1);
            chk("single_res", 32'(rsp_q[0].res), 32'd1);
            chk("single_err", 32'(rsp_q[0].err), 32'd0);
            chk("single_lat", 32'(rsp_q[0].c - acc_c[0]), 32'd22);
        end

        // tie straight from reset
        do_reset(2);
        clr_logs();
        rnd_ops();
        req_valid = 2'b11;
        wait_idle(200);
        chk("tie_cnt", 32'(rsp_q.size()), 32'd2);
        if (rsp_q.size() == 2) begin
            chk("tie_first", 32'(rsp_q[0].v), 32'd1);
            chk("tie_second", 32'(rsp_q[1].v), 32'd2);
        end

        // back-to-back ties alternate
        clr_logs();
        rnd_ops();
        req_valid = 2'b11;
        for (int n = 0; n < 400 && acc_g.size() < 4; n++) begin
            step();
            req_valid = (acc_g.size() < 4) ? 2'b11 : 2'b00;
        end
        req_valid = 2'b00;
        wait_idle(100);
        chk("b2b_cnt", 32'(acc_g.size()), 32'd4);
        if (acc_g.size() == 4)
            for (int i = 0; i < 4; i++) chk("b2b_grant", 32'(acc_g[i]), 32'(i % 2));

        // timeout: core never answers
        clr_logs();
        core_dly = 0;
        rnd_ops();
        req_valid = 2'b10;
        wait_idle(100);
        chk("tmo_cnt", 32'(rsp_q.size()), 32'd1);
        if (rsp_q.size() == 1 && acc_c.size() == 1) begin
            chk("tmo_v", 32'(rsp_q[0].v), 32'd2);
            chk("tmo_err", 32'(rsp_q[0].err), 32'd1);
            chk("tmo_res", 32'(rsp_q[0].res), 32'd0);
            chk("tmo_lat", 32'(rsp_q[0].c - acc_c[0]), 32'(TMO + 2));
        end

        // core_val on the expiry cycle wins
        clr_logs();
        core_dly = TMO;
        rnd_ops();
        req_valid = 2'b01;
        wait_idle(100);
        chk("edge_cnt", 32'(rsp_q.size()), 32'd1);
        if (rsp_q.size() == 1 && acc_c.size() == 1) begin
            chk("edge_err", 32'(rsp_q[0].err), 32'd0);
            chk("edge_lat", 32'(rsp_q[0].c - acc_c[0]), 32'(TMO + 2));
        end

        // stray core_val while idle
        clr_logs();
        stray_cyc = cyc + 3;
        repeat (6) step();
        stray_cyc = -1;
        chk("stray_rsp", 32'(rsp_q.size()), 32'd0);

        // reset in the middle of WAIT, then a late core_val
        clr_logs();
        core_dly = 20;
        rnd_ops();
        req_valid = 2'b01;
        for (int n = 0; n < 50 && acc_c.size() == 0; n++) step();
        for (int n = 0; n < 50 && acc_c.size() > 0 && cyc < acc_c[0] + 12; n++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (25) step();
        chk("abort_rsp", 32'(rsp_q.size()), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        clr_logs();
        rnd_ops();
        req_valid = 2'b10;
        wait_idle(100);
        chk("post_rst_cnt", 32'(rsp_q.size()), 32'd1);
        if (rsp_q.size() == 1) begin
            chk("post_rst_v", 32'(rsp_q[0].v), 32'd2);
            chk("post_rst_err", 32'(rsp_q[0].err), 32'd0);
        end

        // random traffic, random core latency including late/never answers
        clr_logs();
        for (int n = 0; n < 1500; n++) begin
            step();
            if (!busy) core_dly = $urandom_range(0, TMO + 2);
            req_valid = 2'($urandom);
            rnd_ops();
        end
        req_valid = 2'b00;
        wait_idle(100);
        chk("rand_balance", 32'(rsp_q.size()), 32'(acc_g.size()));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
